key_event_decoder: RTL and testbench
====================================

# key_event_decoder

Turns the raw PS/2 scan-code byte stream from the keyboard receiver into discrete press/release events and a held-key bitmask for the game logic. It sits directly downstream of the PS/2 receiver: one byte and strobe in, one-cycle event pulses and a level-type `key_state` vector out. It handles Set-2 prefixes (E0 extended, F0 break), skips the E1 Pause sequence, drops keyboard status bytes, and recovers from truncated sequences with a timeout.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1_300_000. Idle clocks (20 ms at 65 MHz) after a prefix byte before the FSM abandons the sequence.
- `SUPPRESS_REPEAT`, default 1. When 1, typematic make codes for an already-held tracked key produce no event.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `data_in`  in  8  received scan-code byte (receiver `keycode[7:0]`)
- `data_valid`  in  1  one-cycle strobe, byte complete (receiver `oflag`)
- `event_valid`  out  1  one-cycle pulse, event fields valid
- `event_code`  out  8  final (non-prefix) scan code
- `event_ext`  out  1  sequence carried E0
- `event_break`  out  1  1 = release, 0 = press
- `key_state`  out  12  held mask, indexed per package key table
- `seq_error`  out  1  one-cycle pulse on timeout or illegal prefix order

## Operation
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), SKIP (E1 Pause sequence).
- IDLE transitions:
  - E0 → EXT.
  - F0 → BRK.
  - E1 → SKIP, with the skip counter set to 7.
  - 00, AA, EE, FA, FC, FE, FF are dropped and the FSM stays in IDLE.
  - Any other byte emits a make event (ext=0).
- EXT transitions:
  - F0 → EXT_BRK.
  - E0 or E1 → `seq_error`, then IDLE.
  - Other bytes emit a make event (ext=1) and return to IDLE.
- BRK:
  - Any byte other than E0/E1/F0 emits a break event (ext=0) and returns to IDLE.
  - A prefix byte → `seq_error`, then IDLE.
- EXT_BRK: same as BRK, but the event has ext=1.
- SKIP: each `data_valid` decrements the counter; the FSM returns to IDLE when it reaches 0. No events are emitted.
- Tracked keys: a match on (ext, code) against the package table drives the matching `key_state` bit.
  - Make sets the bit; break clears it.
  - Untracked keys emit events but leave `key_state` unchanged.
  - A break for a tracked key that is not held still emits an event; the bit stays 0.
- Repeat suppression (SUPPRESS_REPEAT=1): a make for a tracked key whose bit is already 1 emits nothing. Repeats of untracked keys always pass.
- Timeout counter:
  - Cleared on every `data_valid`; counts only while the FSM is in EXT, BRK, EXT_BRK or SKIP.
  - On reaching TIMEOUT_CYCLES−1: `seq_error` pulses, FSM → IDLE, `key_state` is unchanged.
  - If `data_valid` arrives in the same cycle the terminal count is reached, the byte wins. It is processed in the current state and no error is raised.

## Timing
- Reset values: FSM=IDLE, all counters 0; `event_valid`, `event_code`, `event_ext`, `event_break`, `key_state`, `seq_error` all 0.
- Latency: `event_valid` and the updated `key_state` appear on the clock edge after the `data_valid` cycle of the final byte, i.e. 1 cycle after the strobe.
- Event fields are registered and hold until the next event. `event_valid` is high for exactly one cycle.
- Back-to-back `data_valid` on consecutive cycles must be accepted with no loss. Every byte is consumed in its strobe cycle; there is no backpressure.
- Reset asserted mid-sequence immediately returns all state to reset values. The bytes that follow are decoded from IDLE.

## Structure
- `keyboard_pkg` holds:
  - the state enum;
  - byte constants (E0, E1, F0 and the ignore-list codes);
  - the 12-entry tracked-key table with index localparams: 0 W=1D, 1 A=1C, 2 S=1B, 3 D=23, 4 UP=E0 75, 5 DOWN=E0 72, 6 LEFT=E0 6B, 7 RIGHT=E0 74, 8 SPACE=29, 9 ENTER=5A, 10 ESC=76, 11 P=4D;
  - a function mapping (ext, code) to {hit, index}.
- One sub-module, `key_seq_timeout`: a loadable 21-bit down-counter with clear, run and expire outputs. The FSM, event registers and held mask stay in the top module.

## Test plan
- Byte 1D → one cycle later `event_valid`=1, code=1D, ext=0, break=0, `key_state[0]`=1. Then F0,1D → break event, `key_state[0]`=0.
- E0,75 then E0,F0,75 → press then release events with ext=1; `key_state[4]` goes 1 then 0. Byte 75 without E0 leaves bit 4 unchanged but still emits an event.
- 1D,1D,1D with SUPPRESS_REPEAT=1 → exactly one event. With SUPPRESS_REPEAT=0 → three events.
- Pause sequence E1,14,77,E1,F0,14,F0,77 → no events, no `seq_error`. A following 29 → make event with `key_state[8]`=1.
- E0 followed by TIMEOUT_CYCLES idle clocks → one `seq_error` pulse, FSM back in IDLE; a following 1C → make (ext=0). Also drive `data_valid` exactly on the terminal-count cycle → no error.
- Bytes AA, FA → no events. Back-to-back strobes F0 then 1D on consecutive cycles → break event. Assert `rst_n` low after E0 → outputs return to 0; a following 72 decodes as ext=0.

Source files
------------

// File: rtl/keyboard_pkg.sv
// keyboard_pkg
// Shared definitions for the PS/2 Set-2 key event decoder:
//   - decoder FSM state encoding
//   - prefix and status byte constants
//   - tracked-key table (index localparams) and lookup helpers
package keyboard_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_SKIP    = 3'd4
  } state_e;

  localparam logic [7:0] CODE_E0 = 8'hE0;
  localparam logic [7:0] CODE_E1 = 8'hE1;
  localparam logic [7:0] CODE_F0 = 8'hF0;

  // Keyboard status / handshake bytes that never start a key sequence
  localparam logic [7:0] CODE_ERR0  = 8'h00;
  localparam logic [7:0] CODE_BAT   = 8'hAA;
  localparam logic [7:0] CODE_ECHO  = 8'hEE;
  localparam logic [7:0] CODE_ACK   = 8'hFA;
  localparam logic [7:0] CODE_BATF  = 8'hFC;
  localparam logic [7:0] CODE_RESND = 8'hFE;
  localparam logic [7:0] CODE_ERR1  = 8'hFF;

  // Bytes remaining after E1 in the Pause make/break sequence
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  localparam int NUM_KEYS = 12;

  localparam logic [3:0] KEY_W     = 4'd0;
  localparam logic [3:0] KEY_A     = 4'd1;
  localparam logic [3:0] KEY_S     = 4'd2;
  localparam logic [3:0] KEY_D     = 4'd3;
  localparam logic [3:0] KEY_UP    = 4'd4;
  localparam logic [3:0] KEY_DOWN  = 4'd5;
  localparam logic [3:0] KEY_LEFT  = 4'd6;
  localparam logic [3:0] KEY_RIGHT = 4'd7;
  localparam logic [3:0] KEY_SPACE = 4'd8;
  localparam logic [3:0] KEY_ENTER = 4'd9;
  localparam logic [3:0] KEY_ESC   = 4'd10;
  localparam logic [3:0] KEY_P     = 4'd11;

  // Returns {hit, index}; index is meaningful only when hit is 1.
  function automatic logic [4:0] key_lookup(input logic ext, input logic [7:0] code);
    logic [4:0] res;
    res = 5'd0;
    case ({ext, code})
      {1'b0, 8'h1D}: res = {1'b1, KEY_W};
      {1'b0, 8'h1C}: res = {1'b1, KEY_A};
      {1'b0, 8'h1B}: res = {1'b1, KEY_S};
      {1'b0, 8'h23}: res = {1'b1, KEY_D};
      {1'b1, 8'h75}: res = {1'b1, KEY_UP};
      {1'b1, 8'h72}: res = {1'b1, KEY_DOWN};
      {1'b1, 8'h6B}: res = {1'b1, KEY_LEFT};
      {1'b1, 8'h74}: res = {1'b1, KEY_RIGHT};
      {1'b0, 8'h29}: res = {1'b1, KEY_SPACE};
      {1'b0, 8'h5A}: res = {1'b1, KEY_ENTER};
      {1'b0, 8'h76}: res = {1'b1, KEY_ESC};
      {1'b0, 8'h4D}: res = {1'b1, KEY_P};
      default:       res = 5'd0;
    endcase
    return res;
  endfunction

  function automatic logic is_status_byte(input logic [7:0] code);
    return (code == CODE_ERR0) || (code == CODE_BAT) || (code == CODE_ECHO) ||
           (code == CODE_ACK) || (code == CODE_BATF) || (code == CODE_RESND) ||
           (code == CODE_ERR1);
  endfunction

endpackage

// File: rtl/key_seq_timeout.sv
// key_seq_timeout
// Loadable 21-bit down-counter that flags an abandoned scan-code sequence.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_value  : value loaded on clear
//   clear       : reload the counter (a byte arrived)
//   run         : count down (a sequence is in progress)
//   expire      : high while running with the counter at zero
module key_seq_timeout (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [20:0] load_value,
  input  logic        clear,
  input  logic        run,
  output logic        expire
);

  logic [20:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = load_value;
    end else if (run && (cnt_q != 21'd0)) begin
      cnt_d = cnt_q - 21'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 21'd0;
    else        cnt_q <= cnt_d;
  end

  assign expire = run && (cnt_q == 21'd0);

endmodule

// File: rtl/key_event_decoder.sv
// key_event_decoder
// Decodes the PS/2 Set-2 byte stream into press/release events and a held-key
// mask for the tracked keys in keyboard_pkg.
//   clk, rst_n             : clock, asynchronous active-low reset
//   data_in, data_valid    : received byte and its one-cycle strobe
//   event_valid            : one-cycle pulse, event_* fields valid (held after)
//   event_code/ext/break   : final scan code, E0 seen, release flag
//   key_state              : held mask of tracked keys
//   seq_error              : one-cycle pulse on timeout or bad prefix order
//   dbg_state              : current decoder state
// Handshake: data_valid is a one-cycle strobe with no ready; every byte is
// consumed in its strobe cycle and results appear one clock later.
module key_event_decoder
  import keyboard_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES  = 1_300_000,
  parameter int unsigned SUPPRESS_REPEAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          data_in,
  input  logic                data_valid,
  output logic                event_valid,
  output logic [7:0]          event_code,
  output logic                event_ext,
  output logic                event_break,
  output logic [NUM_KEYS-1:0] key_state,
  output logic                seq_error,
  output state_e              dbg_state
);

  localparam logic [20:0] TIMEOUT_LOAD = 21'(TIMEOUT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [2:0]          skip_q, skip_d;
  logic                event_valid_q, event_valid_d;
  logic [7:0]          event_code_q, event_code_d;
  logic                event_ext_q, event_ext_d;
  logic                event_break_q, event_break_d;
  logic [NUM_KEYS-1:0] key_state_q, key_state_d;
  logic                seq_error_q, seq_error_d;

  logic                expire;
  logic                emit_req, emit_ext, emit_brk;
  logic [4:0]          lookup;
  logic [NUM_KEYS-1:0] key_mask;
  logic                is_repeat;

  key_seq_timeout u_timeout (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_value (TIMEOUT_LOAD),
    .clear      (data_valid),
    .run        (state_q != ST_IDLE),
    .expire     (expire)
  );

  // Sequence decoding: decides whether this byte ends a sequence
  always_comb begin
    state_d     = state_q;
    skip_d      = skip_q;
    seq_error_d = 1'b0;
    emit_req    = 1'b0;
    emit_ext    = 1'b0;
    emit_brk    = 1'b0;
    if (data_valid) begin
      // A byte on the terminal-count cycle takes priority over the timeout
      case (state_q)
        ST_IDLE: begin
          if (data_in == CODE_E0) begin
            state_d = ST_EXT;
          end else if (data_in == CODE_F0) begin
            state_d = ST_BRK;
          end else if (data_in == CODE_E1) begin
            state_d = ST_SKIP;
            skip_d  = PAUSE_SKIP;
          end else if (!is_status_byte(data_in)) begin
            emit_req = 1'b1;
          end
        end
        ST_EXT: begin
          if (data_in == CODE_F0) begin
            state_d = ST_EXT_BRK;
          end else if ((data_in == CODE_E0) || (data_in == CODE_E1)) begin
            seq_error_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            emit_req = 1'b1;
            emit_ext = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          state_d = ST_IDLE;
          if ((data_in == CODE_E0) || (data_in == CODE_E1) || (data_in == CODE_F0)) begin
            seq_error_d = 1'b1;
          end else begin
            emit_req = 1'b1;
            emit_brk = 1'b1;
            emit_ext = (state_q == ST_EXT_BRK);
          end
        end
        ST_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q <= 3'd1) begin
            skip_d  = 3'd0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (expire) begin
      seq_error_d = 1'b1;
      state_d     = ST_IDLE;
      skip_d      = 3'd0;
    end
  end

  // Event generation and held-mask update
  always_comb begin
    event_valid_d = 1'b0;
    event_code_d  = event_code_q;
    event_ext_d   = event_ext_q;
    event_break_d = event_break_q;
    key_state_d   = key_state_q;
    lookup        = key_lookup(emit_ext, data_in);
    key_mask      = lookup[4] ? (NUM_KEYS'(1) << lookup[3:0]) : '0;
    is_repeat     = !emit_brk && (SUPPRESS_REPEAT != 0) && ((key_state_q & key_mask) != '0);
    if (emit_req) begin
      if (!is_repeat) begin
        event_valid_d = 1'b1;
        event_code_d  = data_in;
        event_ext_d   = emit_ext;
        event_break_d = emit_brk;
      end
      if (emit_brk) key_state_d = key_state_q & ~key_mask;
      else          key_state_d = key_state_q | key_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      skip_q        <= 3'd0;
      event_valid_q <= 1'b0;
      event_code_q  <= 8'd0;
      event_ext_q   <= 1'b0;
      event_break_q <= 1'b0;
      key_state_q   <= '0;
      seq_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      skip_q        <= skip_d;
      event_valid_q <= event_valid_d;
      event_code_q  <= event_code_d;
      event_ext_q   <= event_ext_d;
      event_break_q <= event_break_d;
      key_state_q   <= key_state_d;
      seq_error_q   <= seq_error_d;
    end
  end

  assign event_valid = event_valid_q;
  assign event_code  = event_code_q;
  assign event_ext   = event_ext_q;
  assign event_break = event_break_q;
  assign key_state   = key_state_q;
  assign seq_error   = seq_error_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// tb_key_event_decoder
// Directed test of key_event_decoder: one instance with repeat suppression,
// one without (sharing the same input stream), and a short timeout.
module tb_key_event_decoder;
  import keyboard_pkg::*;

  localparam int unsigned TO = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic data_valid = 1'b0;

  always #5 clk = ~clk;

  logic          event_valid, event_ext, event_break, seq_error;
  logic [7:0]    event_code;
  logic [11:0]   key_state;
  state_e        dbg_state;

  logic          nr_event_valid, nr_event_ext, nr_event_break, nr_seq_error;
  logic [7:0]    nr_event_code;
  logic [11:0]   nr_key_state;
  state_e        nr_dbg_state;

  key_event_decoder #(.TIMEOUT_CYCLES(TO), .SUPPRESS_REPEAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .event_valid(event_valid), .event_code(event_code), .event_ext(event_ext),
    .event_break(event_break), .key_state(key_state), .seq_error(seq_error),
    .dbg_state(dbg_state)
  );

  key_event_decoder #(.TIMEOUT_CYCLES(TO), .SUPPRESS_REPEAT(0)) dut_nr (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .event_valid(nr_event_valid), .event_code(nr_event_code), .event_ext(nr_event_ext),
    .event_break(nr_event_break), .key_state(nr_key_state), .seq_error(nr_seq_error),
    .dbg_state(nr_dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int tests_run = 0;
  int tests_failed = 0;
  int ev_cnt = 0;
  int err_cnt = 0;
  int ev_nr_cnt = 0;

  always @(negedge clk) begin
    if (event_valid)    ev_cnt++;
    if (seq_error)      err_cnt++;
    if (nr_event_valid) ev_nr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    data_in    = b;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [7:0] b1, input logic [7:0] b2);
    @(negedge clk);
    data_in    = b1;
    data_valid = 1'b1;
    @(negedge clk);
    data_in    = b2;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic check_ev(input string tag, input logic [7:0] code, input logic ext,
                          input logic brk, input logic [11:0] ks);
    check({tag, " valid"}, 32'(event_valid), 32'd1);
    check({tag, " code"},  32'(event_code), 32'(code));
    check({tag, " ext"},   32'(event_ext), 32'(ext));
    check({tag, " break"}, 32'(event_break), 32'(brk));
    check({tag, " keys"},  32'(key_state), 32'(ks));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int e0, n0, x0;
    logic [7:0] pause_seq [8];
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    repeat (3) @(negedge clk);
    check("rst valid", 32'(event_valid), 32'd0);
    check("rst code",  32'(event_code), 32'd0);
    check("rst keys",  32'(key_state), 32'd0);
    check("rst err",   32'(seq_error), 32'd0);
    check("rst state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;

    // W press, single-cycle pulse with held fields, then release
    send_byte(8'h1D);
    check_ev("w make", 8'h1D, 1'b0, 1'b0, 12'h001);
    @(negedge clk);
    check("w pulse", 32'(event_valid), 32'd0);
    check("w hold", 32'(event_code), 32'h1D);
    send_byte(8'hF0);
    check("f0 no ev", 32'(event_valid), 32'd0);
    send_byte(8'h1D);
    check_ev("w break", 8'h1D, 1'b0, 1'b1, 12'h000);

    // Extended UP press/release, then bare 75 (untracked)
    send_byte(8'hE0); send_byte(8'h75);
    check_ev("up make", 8'h75, 1'b1, 1'b0, 12'h010);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    check_ev("up break", 8'h75, 1'b1, 1'b1, 12'h000);
    send_byte(8'h75);
    check_ev("kp8 make", 8'h75, 1'b0, 1'b0, 12'h000);

    // Typematic repeat
    settle();
    e0 = ev_cnt; n0 = ev_nr_cnt;
    send_byte(8'h1D); send_byte(8'h1D); send_byte(8'h1D);
    settle();
    check("repeat sup", 32'(ev_cnt - e0), 32'd1);
    check("repeat nosup", 32'(ev_nr_cnt - n0), 32'd3);
    check("repeat keys", 32'(key_state), 32'h001);
    send_byte(8'hF0); send_byte(8'h1D);
    check("w clr keys", 32'(key_state), 32'h000);

    // Pause sequence is skipped silently
    settle();
    e0 = ev_cnt; x0 = err_cnt;
    foreach (pause_seq[i]) send_byte(pause_seq[i]);
    settle();
    check("pause ev", 32'(ev_cnt - e0), 32'd0);
    check("pause err", 32'(err_cnt - x0), 32'd0);
    check("pause state", 32'(dbg_state), 32'(ST_IDLE));
    send_byte(8'h29);
    check_ev("space make", 8'h29, 1'b0, 1'b0, 12'h100);

    // Timeout after E0
    settle();
    x0 = err_cnt;
    send_byte(8'hE0);
    repeat (TO - 1) @(negedge clk);
    check("to early err", 32'(seq_error), 32'd0);
    check("to early state", 32'(dbg_state), 32'(ST_EXT));
    @(negedge clk);
    check("to err", 32'(seq_error), 32'd1);
    check("to state", 32'(dbg_state), 32'(ST_IDLE));
    check("to keys", 32'(key_state), 32'h100);
    @(negedge clk);
    check("to pulse", 32'(seq_error), 32'd0);
    send_byte(8'h1C);
    check_ev("a make", 8'h1C, 1'b0, 1'b0, 12'h102);
    settle();
    check("to err count", 32'(err_cnt - x0), 32'd1);

    // Byte on the terminal-count cycle wins
    x0 = err_cnt;
    send_byte(8'hE0);
    repeat (TO - 2) @(negedge clk);
    send_byte(8'h75);
    check_ev("tc up make", 8'h75, 1'b1, 1'b0, 12'h112);
    repeat (TO + 4) @(negedge clk);
    #1;
    check("tc no err", 32'(err_cnt - x0), 32'd0);

    // Status bytes dropped
    e0 = ev_cnt;
    send_byte(8'hAA); send_byte(8'hFA);
    settle();
    check("status ev", 32'(ev_cnt - e0), 32'd0);

    // Back-to-back F0,1D
    send_byte(8'h1D);
    check("w2 keys", 32'(key_state), 32'h113);
    send_pair(8'hF0, 8'h1D);
    check_ev("b2b break", 8'h1D, 1'b0, 1'b1, 12'h112);

    // Reset mid-sequence
    send_byte(8'hE0);
    #2 rst_n = 1'b0;
    #1;
    check("mid rst code", 32'(event_code), 32'd0);
    check("mid rst keys", 32'(key_state), 32'd0);
    check("mid rst break", 32'(event_break), 32'd0);
    check("mid rst state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h72);
    check_ev("post rst 72", 8'h72, 1'b0, 1'b0, 12'h000);

    settle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
